// File: rtl/regfile_writebacker_pkg.sv
// Shared widths, the x0 constant and the write-back record used by the
// regfile write-back block and its bypass muxes.
package regfile_writebacker_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  // One in-flight register write: a source of bypass data and of array updates.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_rec_t;

endpackage

// File: rtl/regfile_writebacker_bypass_mux.sv
// One read port: picks the youngest in-flight write to the addressed register,
// falling back to the array. x0 always reads zero.
module regfile_bypass_mux
  import regfile_writebacker_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  wb_rec_t               ld_src,
  input  wb_rec_t               ex_src,
  input  wb_rec_t               wb_src,
  input  logic [XLEN-1:0]       array_data,
  output logic [XLEN-1:0]       data
);

  // Priority: returning load > retiring ALU result > WB register > array.
  always_comb begin
    // NOTE: default assigned first so every path drives data; no latch is inferred.
    data = array_data;
    if (addr == X0)                                  data = '0;
    else if (ld_src.valid && (ld_src.rd == addr))    data = ld_src.data;
    else if (ex_src.valid && (ex_src.rd == addr))    data = ex_src.data;
    else if (wb_src.valid && (wb_src.rd == addr))    data = wb_src.data;
  end

endmodule

// File: rtl/regfile_writebacker.sv
// Write-back end of the execute datapath: 32x32 register file, one-entry ALU
// write-back register, full read bypassing and a pending-load scoreboard.
module regfile_writebacker
  import regfile_writebacker_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] RS2_ADDR,
  output logic [XLEN-1:0]       RS1_VAL,
  output logic [XLEN-1:0]       RS2_VAL,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_RD,
  input  logic                  ISSUE_USES_RS1,
  input  logic                  ISSUE_USES_RS2,
  input  logic                  ISSUE_IS_LOAD,
  output logic                  HAZARD,
  input  logic                  EX_VALID,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic [XLEN-1:0]       EX_RESULT,
  input  logic                  LD_VALID,
  input  logic [REG_ADDR_W-1:0] LD_RD,
  input  logic [XLEN-1:0]       LD_DATA,
  output logic                  WB_VALID,
  output logic [REG_ADDR_W-1:0] WB_RD,
  output logic [XLEN-1:0]       WB_DATA,
  output logic [NREG-1:0]       PENDING
);

  logic [XLEN-1:0] regs [NREG];
  wb_rec_t         wb_q;
  wb_rec_t         ld_rec;
  wb_rec_t         ex_rec;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_eff;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            issue_load;

  // Writes to x0 are dropped at the source, so they never bypass or commit.
  assign ld_rec = '{valid: LD_VALID && (LD_RD != X0), rd: LD_RD, data: LD_DATA};
  assign ex_rec = '{valid: EX_VALID && (EX_RD != X0), rd: EX_RD, data: EX_RESULT};

  // A load returning this cycle satisfies its dependents through the bypass.
  assign clr_mask    = ld_rec.valid ? (NREG'(1) << LD_RD) : '0;
  assign pending_eff = pending_q & ~clr_mask;

  // Stall on RAW against sources actually read, and on WAW against the destination.
  assign HAZARD = ISSUE_VALID &&
                  ((ISSUE_USES_RS1 && pending_eff[RS1_ADDR]) ||
                   (ISSUE_USES_RS2 && pending_eff[RS2_ADDR]) ||
                   pending_eff[ISSUE_RD]);

  assign issue_load = ISSUE_VALID && ISSUE_IS_LOAD && !HAZARD && (ISSUE_RD != X0);
  assign set_mask   = issue_load ? (NREG'(1) << ISSUE_RD) : '0;

  // Write-back register and scoreboard; set wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_q      <= '0;
      pending_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      wb_q      <= ex_rec.valid ? ex_rec : '0;
      pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~NREG'(1);
    end
  end

  // Register array: loads commit directly, ALU results one edge later from wb_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the array is architecturally cleared on reset, so this memory is reset explicitly.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_q.valid) regs[wb_q.rd] <= wb_q.data;
      // Listed last so a returning load wins over an older ALU commit to the same rd.
      if (ld_rec.valid) regs[LD_RD] <= LD_DATA;
    end
  end

  regfile_bypass_mux u_rs1_mux (
    .addr       (RS1_ADDR),
    .ld_src     (ld_rec),
    .ex_src     (ex_rec),
    .wb_src     (wb_q),
    .array_data (regs[RS1_ADDR]),
    .data       (RS1_VAL)
  );

  regfile_bypass_mux u_rs2_mux (
    .addr       (RS2_ADDR),
    .ld_src     (ld_rec),
    .ex_src     (ex_rec),
    .wb_src     (wb_q),
    .array_data (regs[RS2_ADDR]),
    .data       (RS2_VAL)
  );

  assign WB_VALID = wb_q.valid;
  assign WB_RD    = wb_q.rd;
  assign WB_DATA  = wb_q.data;
  assign PENDING  = pending_q;

endmodule

// File: tb/tb_regfile_writebacker.sv
// Directed, table-driven bench for regfile_writebacker. Each table row holds
// one cycle of inputs and the outputs expected during that cycle.
module tb_regfile_writebacker;
  import regfile_writebacker_pkg::*;

  logic                  CLK, RST;
  logic [REG_ADDR_W-1:0] RS1_ADDR, RS2_ADDR, ISSUE_RD, EX_RD, LD_RD, WB_RD;
  logic [XLEN-1:0]       RS1_VAL, RS2_VAL, EX_RESULT, LD_DATA, WB_DATA;
  logic                  ISSUE_VALID, ISSUE_USES_RS1, ISSUE_USES_RS2, ISSUE_IS_LOAD;
  logic                  HAZARD, EX_VALID, LD_VALID, WB_VALID;
  logic [NREG-1:0]       PENDING;

  regfile_writebacker dut (
    .CLK(CLK), .RST(RST), .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .ISSUE_VALID(ISSUE_VALID),
    .ISSUE_RD(ISSUE_RD), .ISSUE_USES_RS1(ISSUE_USES_RS1),
    .ISSUE_USES_RS2(ISSUE_USES_RS2), .ISSUE_IS_LOAD(ISSUE_IS_LOAD),
    .HAZARD(HAZARD), .EX_VALID(EX_VALID), .EX_RD(EX_RD), .EX_RESULT(EX_RESULT),
    .LD_VALID(LD_VALID), .LD_RD(LD_RD), .LD_DATA(LD_DATA),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .PENDING(PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic        iv, u1, u2, il;
    logic [4:0]  ird;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        ldv;
    logic [4:0]  ldrd;
    logic [31:0] lddata;
    logic [31:0] e_rs1, e_rs2;
    logic        e_haz;
    logic        e_wbv;
    logic [4:0]  e_wbrd;
    logic [31:0] e_wbdata;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];
  vec_t t;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RST = v.rst; RS1_ADDR = v.rs1; RS2_ADDR = v.rs2;
    ISSUE_VALID = v.iv; ISSUE_RD = v.ird; ISSUE_USES_RS1 = v.u1;
    ISSUE_USES_RS2 = v.u2; ISSUE_IS_LOAD = v.il;
    EX_VALID = v.exv; EX_RD = v.exrd; EX_RESULT = v.exres;
    LD_VALID = v.ldv; LD_RD = v.ldrd; LD_DATA = v.lddata;
  endtask

  // Clear a row; all expected values default to the idle/zero state.
  function automatic vec_t blank();
    vec_t b;
    b = '{default: '0};
    return b;
  endfunction

  initial begin
    // Reset for two cycles.
    t = blank(); t.rst = 1'b1; drive(t);
    repeat (2) @(posedge CLK);
    #1;
    t = blank(); drive(t);

    // After reset every address reads zero; nothing pending, no hazard.
    for (int i = 0; i < NREG; i++) begin
      RS1_ADDR = 5'(i); RS2_ADDR = 5'(31 - i);
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'(i); ISSUE_USES_RS1 = 1'b1; ISSUE_USES_RS2 = 1'b1;
      #1;
      check($sformatf("reset_rs1[%0d]", i), 64'(RS1_VAL), 64'h0);
      check($sformatf("reset_rs2[%0d]", 31 - i), 64'(RS2_VAL), 64'h0);
      check($sformatf("reset_haz[%0d]", i), 64'(HAZARD), 64'h0);
    end
    check("reset_pending", 64'(PENDING), 64'h0);
    check("reset_wb", {WB_VALID, WB_RD, WB_DATA}, 64'h0);

    // ALU write to x5: EX bypass, WB bypass, then array.
    t = blank(); t.exv = 1; t.exrd = 5; t.exres = 32'hDEADBEEF; t.rs1 = 5; t.e_rs1 = 32'hDEADBEEF; vecs.push_back(t);
    t = blank(); t.rs1 = 5; t.e_rs1 = 32'hDEADBEEF; t.e_wbv = 1; t.e_wbrd = 5; t.e_wbdata = 32'hDEADBEEF; vecs.push_back(t);
    t = blank(); t.rs1 = 5; t.rs2 = 5; t.e_rs1 = 32'hDEADBEEF; t.e_rs2 = 32'hDEADBEEF; vecs.push_back(t);
    // Load to x7, RAW stall until data returns.
    t = blank(); t.iv = 1; t.il = 1; t.ird = 7; t.rs1 = 7; vecs.push_back(t);
    t = blank(); t.iv = 1; t.u1 = 1; t.rs1 = 7; t.ird = 8; t.e_haz = 1; t.e_pend = 32'h80; vecs.push_back(t);
    t = blank(); t.iv = 1; t.u1 = 1; t.rs1 = 7; t.ird = 8; t.ldv = 1; t.ldrd = 7; t.lddata = 32'h12345678;
    t.e_rs1 = 32'h12345678; t.e_pend = 32'h80; vecs.push_back(t);
    t = blank(); t.rs1 = 7; t.e_rs1 = 32'h12345678; vecs.push_back(t);
    // Load to x9, then WAW stall from an ALU op writing x9.
    t = blank(); t.iv = 1; t.il = 1; t.ird = 9; vecs.push_back(t);
    t = blank(); t.iv = 1; t.ird = 9; t.rs1 = 1; t.rs2 = 2; t.e_haz = 1; t.e_pend = 32'h200; vecs.push_back(t);
    t = blank(); t.iv = 1; t.ird = 9; t.rs1 = 1; t.rs2 = 2; t.e_haz = 1; t.e_pend = 32'h200; vecs.push_back(t);
    t = blank(); t.iv = 1; t.ird = 9; t.rs1 = 9; t.ldv = 1; t.ldrd = 9; t.lddata = 32'hA5A5A5A5;
    t.e_rs1 = 32'hA5A5A5A5; t.e_pend = 32'h200; vecs.push_back(t);
    t = blank(); t.rs1 = 9; t.e_rs1 = 32'hA5A5A5A5; vecs.push_back(t);
    // x0: writes dropped, never pending, never a hazard.
    t = blank(); t.exv = 1; t.exrd = 0; t.exres = '1; t.ldv = 1; t.ldrd = 0; t.lddata = '1;
    t.iv = 1; t.il = 1; t.ird = 0; t.u1 = 1; t.u2 = 1; vecs.push_back(t);
    t = blank(); t.iv = 1; t.ird = 0; t.u1 = 1; t.u2 = 1; vecs.push_back(t);
    // Same-rd EX and LD: LD bypass wins, array ends with the EX value.
    t = blank(); t.exv = 1; t.exrd = 4; t.exres = 32'h11111111; t.ldv = 1; t.ldrd = 4; t.lddata = 32'h22222222;
    t.rs1 = 4; t.rs2 = 5; t.e_rs1 = 32'h22222222; t.e_rs2 = 32'hDEADBEEF; vecs.push_back(t);
    t = blank(); t.rs1 = 4; t.e_rs1 = 32'h11111111; t.e_wbv = 1; t.e_wbrd = 4; t.e_wbdata = 32'h11111111; vecs.push_back(t);
    t = blank(); t.rs1 = 4; t.e_rs1 = 32'h11111111; vecs.push_back(t);
    // EX input beats the WB register for the same register.
    t = blank(); t.exv = 1; t.exrd = 6; t.exres = 32'h6; vecs.push_back(t);
    t = blank(); t.exv = 1; t.exrd = 6; t.exres = 32'h66; t.rs1 = 6; t.e_rs1 = 32'h66;
    t.e_wbv = 1; t.e_wbrd = 6; t.e_wbdata = 32'h6; vecs.push_back(t);
    t = blank(); t.rs1 = 6; t.rs2 = 6; t.e_rs1 = 32'h66; t.e_rs2 = 32'h66;
    t.e_wbv = 1; t.e_wbrd = 6; t.e_wbdata = 32'h66; vecs.push_back(t);
    // Load return and new load issue to x10 in the same cycle: set wins.
    t = blank(); t.iv = 1; t.il = 1; t.ird = 10; vecs.push_back(t);
    t = blank(); t.iv = 1; t.il = 1; t.ird = 10; t.ldv = 1; t.ldrd = 10; t.lddata = 32'hBB;
    t.rs2 = 10; t.e_rs2 = 32'hBB; t.e_pend = 32'h400; vecs.push_back(t);
    t = blank(); t.rs2 = 10; t.e_rs2 = 32'hBB; t.e_pend = 32'h400; vecs.push_back(t);
    t = blank(); t.ldv = 1; t.ldrd = 10; t.lddata = 32'hCC; t.e_pend = 32'h400; vecs.push_back(t);
    t = blank(); t.rs1 = 10; t.e_rs1 = 32'hCC; vecs.push_back(t);
    // Load return to a non-pending register still writes the array.
    t = blank(); t.ldv = 1; t.ldrd = 11; t.lddata = 32'h77; t.rs2 = 11; t.e_rs2 = 32'h77; vecs.push_back(t);
    t = blank(); t.rs2 = 11; t.e_rs2 = 32'h77; vecs.push_back(t);
    // Reset with writes and a pending load in flight.
    t = blank(); t.exv = 1; t.exrd = 3; t.exres = 32'h33; t.iv = 1; t.il = 1; t.ird = 14;
    t.rs1 = 3; t.e_rs1 = 32'h33; vecs.push_back(t);
    t = blank(); t.rst = 1; t.exv = 1; t.exrd = 3; t.exres = 32'h44; t.ldv = 1; t.ldrd = 12; t.lddata = 32'h99;
    t.iv = 1; t.il = 1; t.ird = 13; t.rs1 = 3; t.rs2 = 12; t.e_rs1 = 32'h44; t.e_rs2 = 32'h99;
    t.e_wbv = 1; t.e_wbrd = 3; t.e_wbdata = 32'h33; t.e_pend = 32'h4000; vecs.push_back(t);
    t = blank(); t.rs1 = 3; t.rs2 = 12; vecs.push_back(t);
    t = blank(); t.rs1 = 5; t.rs2 = 4; t.iv = 1; t.ird = 14; t.u1 = 1; vecs.push_back(t);

    // Apply each row one cycle at a time and compare mid-cycle.
    foreach (vecs[i]) begin
      @(posedge CLK);
      #1;
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d_rs1", i), 64'(RS1_VAL), 64'(vecs[i].e_rs1));
      check($sformatf("v%0d_rs2", i), 64'(RS2_VAL), 64'(vecs[i].e_rs2));
      check($sformatf("v%0d_hazard", i), 64'(HAZARD), 64'(vecs[i].e_haz));
      check($sformatf("v%0d_wb", i), 64'({WB_VALID, WB_RD, WB_DATA}),
            64'({vecs[i].e_wbv, vecs[i].e_wbrd, vecs[i].e_wbdata}));
      check($sformatf("v%0d_pending", i), 64'(PENDING), 64'(vecs[i].e_pend));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
